// File: rtl/arp_sequencer.sv
// Arpeggiator: steps through held keys (up / down / up-down) with per-step gate timing.
// Optional macro ARP_LATCH_EN: play from a latched key pattern that survives key release.
module arp_sequencer #(
  parameter int NUM_KEYS = 8,
  parameter int CNT_W    = 16
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        Enable,
  input  logic [NUM_KEYS-1:0]         keys,
  input  logic [1:0]                  mode,
  input  logic [CNT_W-1:0]            countermax,
  input  logic [CNT_W-1:0]            gate,
  output logic [NUM_KEYS-1:0]         out,
  output logic                        step_strobe,
  output logic [$clog2(NUM_KEYS)-1:0] cur_idx
);

  localparam int IW = $clog2(NUM_KEYS);

  typedef enum logic [1:0] {
    ST_BYPASS = 2'd0,
    ST_WAIT   = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [NUM_KEYS-1:0] out_reg, out_next;
  logic                strobe_reg, strobe_next;
  logic [IW-1:0]       idx_reg, idx_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                dir_reg, dir_next;      // 1 = scanning downward
  logic [NUM_KEYS-1:0] play_keys;
  logic [NUM_KEYS-1:0] onehot_next;
  logic [IW:0]         above, below;           // {found, index}
  logic [IW-1:0]       lowest, highest;

`ifdef ARP_LATCH_EN
  localparam bit LATCH_EN = 1'b1;
  logic [NUM_KEYS-1:0] latch_reg, latch_next;
  logic                released_reg;

  // The first press after an all-released interval replaces the pattern.
  always_comb begin
    latch_next = latch_reg;
    if (keys != '0)
      latch_next = released_reg ? keys : (latch_reg | keys);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      latch_reg    <= '0;
      released_reg <= 1'b1;
    end else begin
      latch_reg    <= latch_next;
      released_reg <= (keys == '0);
    end
  end

  assign play_keys = latch_next;
`else
  localparam bit LATCH_EN = 1'b0;
  assign play_keys = keys;
`endif

  function automatic logic [IW:0] first_above(input logic [NUM_KEYS-1:0] k, input logic [IW-1:0] from);
    logic [IW:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (i > int'(from) && k[i]) r = {1'b1, IW'(i)};
    return r;
  endfunction

  function automatic logic [IW:0] first_below(input logic [NUM_KEYS-1:0] k, input logic [IW-1:0] from);
    logic [IW:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (i < int'(from) && k[i]) r = {1'b1, IW'(i)};
    return r;
  endfunction

  function automatic logic [IW-1:0] lowest_held(input logic [NUM_KEYS-1:0] k);
    logic [IW-1:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (k[i]) r = IW'(i);
    return r;
  endfunction

  function automatic logic [IW-1:0] highest_held(input logic [NUM_KEYS-1:0] k);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (k[i]) r = IW'(i);
    return r;
  endfunction

  assign above   = first_above(play_keys, idx_reg);
  assign below   = first_below(play_keys, idx_reg);
  assign lowest  = lowest_held(play_keys);
  assign highest = highest_held(play_keys);

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    cnt_next    = cnt_reg;
    dir_next    = dir_reg;
    strobe_next = 1'b0;
    case (state_reg)
      ST_BYPASS: begin
        if (Enable) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!Enable) begin
          state_next = ST_BYPASS;
        end else if (play_keys != '0) begin
          state_next  = ST_PLAY;
          cnt_next    = '0;
          strobe_next = 1'b1;
          dir_next    = (mode == 2'b01);
          idx_next    = (mode == 2'b01) ? highest : lowest;
        end
      end
      ST_PLAY: begin
        if (!Enable) begin
          state_next = ST_BYPASS;
        end else if (!LATCH_EN && play_keys == '0) begin
          state_next = ST_WAIT;
        end else if (cnt_reg >= countermax || (!LATCH_EN && !play_keys[idx_reg])) begin
          cnt_next    = '0;
          strobe_next = 1'b1;
          case (mode)
            2'b01: begin
              dir_next = 1'b1;
              idx_next = below[IW] ? below[IW-1:0] : highest;
            end
            2'b10: begin
              // Reverse at the outermost held key; a lone key just repeats.
              if (!dir_reg) begin
                if (above[IW]) idx_next = above[IW-1:0];
                else if (below[IW]) begin
                  idx_next = below[IW-1:0];
                  dir_next = 1'b1;
                end
              end else begin
                if (below[IW]) idx_next = below[IW-1:0];
                else if (above[IW]) begin
                  idx_next = above[IW-1:0];
                  dir_next = 1'b0;
                end
              end
            end
            default: begin
              dir_next = 1'b0;
              idx_next = above[IW] ? above[IW-1:0] : lowest;
            end
          endcase
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_BYPASS;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_onehot
      assign onehot_next[gi] = (idx_next == IW'(gi));
    end
  endgenerate

  // Output is derived from the next state so note, index and strobe line up.
  always_comb begin
    out_next = '0;
    case (state_next)
      ST_BYPASS: out_next = keys;
      ST_PLAY: begin
        if (cnt_next < gate && play_keys[idx_next]) out_next = onehot_next;
      end
      default: out_next = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= ST_BYPASS;
      out_reg    <= '0;
      strobe_reg <= 1'b0;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      dir_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      out_reg    <= out_next;
      strobe_reg <= strobe_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
    end
  end

  assign out         = out_reg;
  assign step_strobe = strobe_reg;
  assign cur_idx     = idx_reg;

endmodule

// File: tb/tb_arp_sequencer.sv
// Self-checking bench for arp_sequencer: directed vectors plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_arp_sequencer;

  localparam int N  = 8;
  localparam int CW = 16;
  localparam int IW = $clog2(N);

  logic          CLK = 1'b0;
  logic          RESET;
  logic          Enable;
  logic [N-1:0]  keys;
  logic [1:0]    mode;
  logic [CW-1:0] countermax;
  logic [CW-1:0] gate;
  logic [N-1:0]  out;
  logic          step_strobe;
  logic [IW-1:0] cur_idx;

  int n_checks = 0;
  int n_fail   = 0;

  arp_sequencer #(.NUM_KEYS(N), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .Enable(Enable), .keys(keys), .mode(mode),
    .countermax(countermax), .gate(gate), .out(out),
    .step_strobe(step_strobe), .cur_idx(cur_idx)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  localparam int M_BYP = 0, M_WAIT = 1, M_PLAY = 2;
  int           m_state = M_BYP;
  logic [N-1:0] m_out   = '0;
  logic         m_strobe = 1'b0;
  int           m_idx = 0;
  int           m_cnt = 0;
  bit           m_down = 1'b0;
`ifdef ARP_LATCH_EN
  localparam bit M_LATCH = 1'b1;
  logic [N-1:0] m_latch = '0;
  bit           m_rel = 1'b1;
`else
  localparam bit M_LATCH = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] note(input logic [N-1:0] k, input int idx, input int cnt);
    logic [N-1:0] v;
    v = '0;
    if (cnt < int'(gate) && k[idx]) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    logic [N-1:0] eff;
    int held[$];
    int above_min, below_max;
    if (RESET) begin
      m_state = M_BYP; m_out = '0; m_strobe = 1'b0;
      m_idx = 0; m_cnt = 0; m_down = 1'b0;
`ifdef ARP_LATCH_EN
      m_latch = '0; m_rel = 1'b1;
`endif
      return;
    end
`ifdef ARP_LATCH_EN
    if (keys != '0) m_latch = m_rel ? keys : (m_latch | keys);
    m_rel = (keys == '0);
    eff = m_latch;
`else
    eff = keys;
`endif
    for (int i = 0; i < N; i++) if (eff[i]) held.push_back(i);
    m_strobe = 1'b0;
    if (!Enable) begin
      m_state = M_BYP;
      m_out = keys;
      return;
    end
    case (m_state)
      M_BYP: begin
        m_state = M_WAIT;
        m_out = '0;
      end
      M_WAIT: begin
        if (held.size() > 0) begin
          m_state = M_PLAY;
          m_cnt = 0;
          m_strobe = 1'b1;
          m_down = (mode == 2'b01);
          m_idx = m_down ? held[held.size()-1] : held[0];
          m_out = note(eff, m_idx, m_cnt);
        end else begin
          m_out = '0;
        end
      end
      default: begin
        if (!M_LATCH && held.size() == 0) begin
          m_state = M_WAIT;
          m_out = '0;
        end else begin
          if (m_cnt >= int'(countermax) || (!M_LATCH && !eff[m_idx])) begin
            above_min = -1;
            below_max = -1;
            foreach (held[j]) begin
              if (held[j] > m_idx && above_min < 0) above_min = held[j];
              if (held[j] < m_idx) below_max = held[j];
            end
            if (mode == 2'b01) begin
              m_down = 1'b1;
              m_idx = (below_max >= 0) ? below_max : held[held.size()-1];
            end else if (mode == 2'b10) begin
              if (!m_down) begin
                if (above_min >= 0) m_idx = above_min;
                else if (below_max >= 0) begin m_idx = below_max; m_down = 1'b1; end
              end else begin
                if (below_max >= 0) m_idx = below_max;
                else if (above_min >= 0) begin m_idx = above_min; m_down = 1'b0; end
              end
            end else begin
              m_down = 1'b0;
              m_idx = (above_min >= 0) ? above_min : held[0];
            end
            m_cnt = 0;
            m_strobe = 1'b1;
          end else begin
            m_cnt++;
          end
          m_out = note(eff, m_idx, m_cnt);
        end
      end
    endcase
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge CLK);
      model_step();
      #1;
      check("model_out", 32'(out), 32'(m_out));
      check("model_strobe", 32'(step_strobe), 32'(m_strobe));
      check("model_idx", 32'(cur_idx), 32'(m_idx));
    end
  endtask

  function automatic logic [N-1:0] rand_keys();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return N'(1) << $urandom_range(0, N-1);
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    logic [N-1:0] exp_up[4];
    int           exp_ud[8];
    exp_up = '{8'h01, 8'h04, 8'h10, 8'h01};
    exp_ud = '{0, 1, 2, 3, 2, 1, 0, 1};

    RESET = 1'b1; Enable = 1'b0; keys = '0; mode = 2'b00;
    countermax = CW'(3); gate = CW'(4);
    run_cycles(2);
    check("rst_out", 32'(out), 32'h0);
    check("rst_idx", 32'(cur_idx), 32'h0);
    $display("reset: out=%0h strobe=%0b idx=%0d", out, step_strobe, cur_idx);

    RESET = 1'b0; keys = 8'h05;
    run_cycles(1);
    check("bypass_out", 32'(out), 32'h05);
    check("bypass_strobe", 32'(step_strobe), 32'h0);
    $display("bypass: keys=05 out=%0h", out);

    Enable = 1'b1; keys = 8'h15;
    run_cycles(1);
    for (int k = 0; k < 16; k++) begin
      run_cycles(1);
      check("up_out", 32'(out), 32'(exp_up[k/4]));
      check("up_strobe", 32'(step_strobe), 32'((k % 4) == 0));
    end
    $display("mode up keys=15: 16 cycles done");

    RESET = 1'b1; run_cycles(1); RESET = 1'b0;
    mode = 2'b10; keys = 8'h0F; countermax = '0; gate = CW'(1);
    run_cycles(1);
    for (int k = 0; k < 8; k++) begin
      run_cycles(1);
      check("updown_idx", 32'(cur_idx), 32'(exp_ud[k]));
    end
    $display("mode up-down keys=0F: 8 cycles done");

    RESET = 1'b1; run_cycles(1); RESET = 1'b0;
    mode = 2'b01; keys = 8'h06; countermax = CW'(9); gate = CW'(2);
    run_cycles(1);
    for (int k = 0; k < 10; k++) begin
      run_cycles(1);
      check("down_out", 32'(out), (k < 2) ? 32'h04 : 32'h0);
    end
    run_cycles(1);
    check("down_next_out", 32'(out), 32'h02);
    check("down_next_strobe", 32'(step_strobe), 32'h1);
    run_cycles(2);
    keys = 8'h04;
    run_cycles(1);
`ifndef ARP_LATCH_EN
    check("release_out", 32'(out), 32'h04);
    check("release_strobe", 32'(step_strobe), 32'h1);
    check("release_idx", 32'(cur_idx), 32'h2);
`endif
    $display("mode down keys=06 with release: done");

    mode = 2'b00; keys = 8'h03; countermax = CW'(1); gate = CW'(2);
    run_cycles(4);
    keys = '0;
    run_cycles(1);
`ifndef ARP_LATCH_EN
    check("allrel_out", 32'(out), 32'h0);
`endif
    run_cycles(3);
    keys = 8'h80;
    run_cycles(6);
    $display("release all then press 80: done");

    keys = 8'h0F; countermax = CW'(5);
    run_cycles(3);
    RESET = 1'b1;
    run_cycles(1);
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_idx", 32'(cur_idx), 32'h0);
    RESET = 1'b0;
    run_cycles(1);
    check("postrst_strobe", 32'(step_strobe), 32'h0);
    run_cycles(4);
    Enable = 1'b0; keys = 8'h0A;
    run_cycles(1);
    check("disable_out", 32'(out), 32'h0A);
    $display("mid-step reset and disable: done");

    Enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) keys = rand_keys();
      if (Enable ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 4) == 0)) Enable = ~Enable;
      RESET = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) countermax = CW'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) gate = CW'($urandom_range(0, 6));
      run_cycles(1);
    end
    $display("random: 4000 cycles done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arp_sequencer.md
ARP_SEQUENCER -- requirements
Module: arp_sequencer

Interface
REQ-001 Parameter NUM_KEYS, default 8: number of key inputs and note outputs, 2..32.
REQ-002 Parameter CNT_W, default 16: width of step-length and gate counters.
REQ-003 CLK  in  1: single clock; all state updates on posedge CLK.
REQ-004 RESET  in  1: synchronous, active-high reset.
REQ-005 Enable  in  1: 1 = arpeggiate; 0 = bypass, keys passed through.
REQ-006 keys  in  NUM_KEYS: key-held flags, bit 0 = lowest note.
REQ-007 mode  in  2: 00 up, 01 down, 10 up-down, 11 treated as up.
REQ-008 countermax  in  CNT_W: step length minus one, in cycles.
REQ-009 gate  in  CNT_W: note-on cycles per step; gate > countermax = legato, full step.
REQ-010 out  out  NUM_KEYS: note-on flags, registered.
REQ-011 step_strobe  out  1: one-cycle pulse on the first cycle of each step.
REQ-012 cur_idx  out  $clog2(NUM_KEYS): index of the key currently sounding.

Function
REQ-013 States SHALL be BYPASS, WAIT, PLAY; all outputs SHALL be registered, with 1-cycle latency from inputs.
REQ-014 BYPASS: out = keys (delayed 1 cycle), step_strobe = 0; Enable=1 -> WAIT.
REQ-015 WAIT: out = 0; when any key is held -> PLAY, with the start index = lowest held key for up/up-down or highest held key for down, and direction = up (down for mode 01).
REQ-016 PLAY: step counter runs 0..countermax; out = one-hot(cur_idx) while counter < gate and keys[cur_idx]=1, else 0.
REQ-017 Step end (counter = countermax) or release of keys[cur_idx] SHALL advance to the next held key on the following cycle, reset the counter to 0 and pulse step_strobe.
REQ-018 Next key search SHALL scan in the current direction with wrap-around for up/down; a single held key SHALL repeat every step.
REQ-019 Up-down SHALL reverse direction at the highest/lowest held key without repeating the endpoint; with one held key it SHALL repeat that key.
REQ-020 No keys held in PLAY -> WAIT next cycle, out = 0.
REQ-021 Enable=0 in any state -> BYPASS next cycle; this SHALL take priority over step advance.
REQ-022 Mode change mid-step SHALL take effect at the next advance; the current note is unaffected.
REQ-023 countermax = 0 SHALL give 1-cycle steps; gate = 0 SHALL give silent steps with step_strobe still pulsing.
REQ-024 A countermax change SHALL apply immediately via the comparison; counter > countermax SHALL be treated as step end.

Reset
REQ-025 RESET=1 SHALL force state BYPASS, out = 0, step_strobe = 0, cur_idx = 0, counter = 0, direction = up, latch register = 0; RESET SHALL take priority over Enable.
REQ-026 A reset asserted mid-step SHALL abort the step, with no strobe on the cycle after reset.

Configuration
REQ-027 Macro ARP_LATCH_EN defined: the key set used by PLAY SHALL be a latch register that ORs in new presses, holds the pattern after all keys are released, and clears then reloads on the first press after an all-released interval; PLAY SHALL NOT exit to WAIT on release, and release of keys[cur_idx] SHALL NOT force an advance.
REQ-028 Macro undefined: the live keys input SHALL be used everywhere; no latch register SHALL exist.

Verification
REQ-029 Reset, Enable=0, keys=8'h05 -> out=8'h05 one cycle later, step_strobe=0.
REQ-030 Enable=1, mode=00, keys=8'h15, countermax=3, gate=4 -> out 01,04,10,01 for 4 cycles each, with a strobe every 4 cycles.
REQ-031 mode=10, keys=8'h0F, countermax=0 -> cur_idx 0,1,2,3,2,1,0,1 on consecutive cycles.
REQ-032 mode=01, keys=8'h06, countermax=9, gate=2 -> out=04 for 2 cycles then 0 for 8 cycles, then out=02; release bit 1 mid-step -> advance on the next cycle.
REQ-033 PLAY with keys=8'h03, then keys=0 -> WAIT and out=0 (macro undefined); with ARP_LATCH_EN the pattern 01,02 continues; a new press of 8'h80 then plays only 80.
REQ-034 RESET pulsed mid-step -> out=0, cur_idx=0 the next cycle; Enable dropped during PLAY -> out=keys the following cycle.
